datapath: RTL and testbench

Execution datapath driven by the 9-bit control word of the sequencing FSM. Holds three `WIDTH`-bit working registers (R1, R2, R3), two operand muxes, a 4-function ALU with a registered result, and a registered comparator. The comparator returns the `mayor` flag that the FSM uses to decide termination. The block sits directly under the FSM in the top level: the FSM's `o_signal` output connects to this block's `i_signal`, and this block's `mayor` output connects back to the FSM's `mayor` input.

---
 rtl/datapath_if.sv | 27 ++
 rtl/datapath.sv | 111 +++++++++++
 tb/tb_datapath.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Control/status bundle between the sequencing FSM side and the execution datapath.
interface datapath_if #(
    parameter int unsigned WIDTH = 8
);
    logic [8:0]       i_signal;
    logic [WIDTH-1:0] i_limit;
    logic             mayor;
    logic [WIDTH-1:0] o_alu;
    logic [WIDTH-1:0] o_r1;
    logic [WIDTH-1:0] o_r2;
    logic [WIDTH-1:0] o_r3;
    logic             o_ovf;
    logic             o_err;
    logic [7:0]       o_wcount;

    // Controller side: issues control word and threshold, observes status.
    modport master (
        output i_signal, i_limit,
        input  mayor, o_alu, o_r1, o_r2, o_r3, o_ovf, o_err, o_wcount
    );

    // Datapath side.
    modport slave (
        input  i_signal, i_limit,
        output mayor, o_alu, o_r1, o_r2, o_r3, o_ovf, o_err, o_wcount
    );
endinterface

// File: rtl/datapath.sv
// Execution datapath: three working registers, two operand muxes, a registered
// 4-function ALU and a registered comparator feeding the FSM's termination flag.
module datapath #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT1 = WIDTH'(0),
    parameter logic [WIDTH-1:0] INIT2 = WIDTH'(1)
) (
    input  logic      clk,
    input  logic      rst,
    datapath_if.slave bus
);
    localparam int unsigned AW = WIDTH + 1;

    logic [1:0] cnt_alu;
    logic [1:0] slc_mux_a;
    logic [1:0] slc_mux_b;
    logic [1:0] slc_reg;
    logic       w;

    logic [WIDTH-1:0] r1, r2, r3;
    logic [WIDTH-1:0] alu_q;
    logic             alu_c;
    logic             mayor_q;
    logic             ovf, err;
    logic [7:0]       wcount;

    logic [WIDTH-1:0] op_a, op_b;
    logic [AW-1:0]    alu_full;

    assign cnt_alu   = bus.i_signal[8:7];
    assign slc_mux_a = bus.i_signal[6:5];
    assign slc_mux_b = bus.i_signal[4:3];
    assign slc_reg   = bus.i_signal[2:1];
    assign w         = bus.i_signal[0];

    // Operand A mux; index 11 reads zero.
    always_comb begin
        op_a = '0;
        case (slc_mux_a)
            2'b00:   op_a = r1;
            2'b01:   op_a = r2;
            2'b10:   op_a = r3;
            default: op_a = '0;
        endcase
    end

    // Operand B mux; index 11 reads zero.
    always_comb begin
        op_b = '0;
        case (slc_mux_b)
            2'b00:   op_b = r1;
            2'b01:   op_b = r2;
            2'b10:   op_b = r3;
            default: op_b = '0;
        endcase
    end

    // ALU at WIDTH+1 bits; top bit is carry for add, borrow for subtract.
    always_comb begin
        alu_full = '0;
        case (cnt_alu)
            2'b00:   alu_full = {1'b0, op_a} + {1'b0, op_b};
            2'b01:   alu_full = {1'b0, op_a} - {1'b0, op_b};
            2'b10:   alu_full = {1'b0, op_a};
            default: alu_full = {1'b0, op_b};
        endcase
    end

    // State update: result/compare registers every cycle, writes use last cycle's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1      <= INIT1;
            r2      <= INIT2;
            r3      <= '0;
            alu_q   <= '0;
            alu_c   <= 1'b0;
            mayor_q <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            wcount  <= 8'd0;
        end else begin
            alu_q   <= alu_full[WIDTH-1:0];
            alu_c   <= alu_full[AW-1];
            mayor_q <= (r3 > bus.i_limit);
            if (w) begin
                if (slc_reg == 2'b11) begin
                    err <= 1'b1;
                end else begin
                    case (slc_reg)
                        2'b00:   r1 <= alu_q;
                        2'b01:   r2 <= alu_q;
                        default: r3 <= alu_q;
                    endcase
                    wcount <= wcount + 8'd1;
                    if (alu_c) begin
                        ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_r1     = r1;
    assign bus.o_r2     = r2;
    assign bus.o_r3     = r3;
    assign bus.o_alu    = alu_q;
    assign bus.mayor    = mayor_q;
    assign bus.o_ovf    = ovf;
    assign bus.o_err    = err;
    assign bus.o_wcount = wcount;
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: two instances (default and 200/100 reset values),
// expectations queued with a due cycle and checked #1 after each rising edge.
module tb_datapath;
    localparam int F_ALU = 0;
    localparam int F_R1  = 1;
    localparam int F_R2  = 2;
    localparam int F_R3  = 3;
    localparam int F_MAY = 4;
    localparam int F_OVF = 5;
    localparam int F_ERR = 6;
    localparam int F_WC  = 7;

    typedef struct {
        int    dut;
        int    fld;
        int    val;
        int    due;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    int   fib [7] = '{1, 2, 3, 5, 8, 13, 21};

    datapath_if #(.WIDTH(8)) a_if();
    datapath_if #(.WIDTH(8)) b_if();

    datapath #(.WIDTH(8), .INIT1(8'd0), .INIT2(8'd1)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    datapath #(.WIDTH(8), .INIT1(8'd200), .INIT2(8'd100)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    always #5 clk = ~clk;

    // Build a control word from its fields.
    function automatic logic [8:0] cw(input int op, input int a, input int b, input int r, input int wr);
        return {2'(op), 2'(a), 2'(b), 2'(r), 1'(wr)};
    endfunction

    function automatic logic [15:0] obs(input int d, input int f);
        logic [15:0] v;
        v = '1;
        if (d == 0) begin
            case (f)
                F_ALU: v = 16'(a_if.o_alu);
                F_R1:  v = 16'(a_if.o_r1);
                F_R2:  v = 16'(a_if.o_r2);
                F_R3:  v = 16'(a_if.o_r3);
                F_MAY: v = 16'(a_if.mayor);
                F_OVF: v = 16'(a_if.o_ovf);
                F_ERR: v = 16'(a_if.o_err);
                F_WC:  v = 16'(a_if.o_wcount);
                default: v = '1;
            endcase
        end else begin
            case (f)
                F_ALU: v = 16'(b_if.o_alu);
                F_R1:  v = 16'(b_if.o_r1);
                F_R2:  v = 16'(b_if.o_r2);
                F_R3:  v = 16'(b_if.o_r3);
                F_MAY: v = 16'(b_if.mayor);
                F_OVF: v = 16'(b_if.o_ovf);
                F_ERR: v = 16'(b_if.o_err);
                F_WC:  v = 16'(b_if.o_wcount);
                default: v = '1;
            endcase
        end
        return v;
    endfunction

    // Queue an expectation due after the next rising edge.
    task automatic push_exp(input int d, input int f, input int v, input string tag);
        exp_t e;
        e.dut = d;
        e.fld = f;
        e.val = v;
        e.due = cyc + 1;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_reset(input int d, input int i1, input int i2, input string tag);
        push_exp(d, F_R1,  i1, {tag, "_r1"});
        push_exp(d, F_R2,  i2, {tag, "_r2"});
        push_exp(d, F_R3,  0,  {tag, "_r3"});
        push_exp(d, F_ALU, 0,  {tag, "_alu"});
        push_exp(d, F_MAY, 0,  {tag, "_mayor"});
        push_exp(d, F_OVF, 0,  {tag, "_ovf"});
        push_exp(d, F_ERR, 0,  {tag, "_err"});
        push_exp(d, F_WC,  0,  {tag, "_wcount"});
    endtask

    // Pop and compare every expectation due this cycle.
    task automatic check_due();
        logic [15:0] o;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                o = obs(sb[i].dut, sb[i].fld);
                checks++;
                assert (o === 16'(sb[i].val)) else begin
                    errors++;
                    $error("FAIL %s observed=%0d expected=%0d", sb[i].tag, o, sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    // Drive both control words and reset, advance one edge, check.
    task automatic step(input logic [8:0] sa, input logic [8:0] sbw, input logic r);
        a_if.i_signal = sa;
        b_if.i_signal = sbw;
        rst = r;
        @(posedge clk);
        cyc++;
        #1;
        check_due();
    endtask

    initial begin
        int m2;
        int prev;
        int f;
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        a_if.i_signal = '0;
        b_if.i_signal = '0;
        a_if.i_limit  = 8'd20;
        b_if.i_limit  = 8'd20;

        // Reset defaults on both instances.
        step(9'd0, 9'd0, 1'b1);
        push_reset(0, 0, 1, "rst_a");
        push_reset(1, 200, 100, "rst_b");
        step(9'd0, 9'd0, 1'b1);

        // Add R1+R2, then write into R3.
        push_exp(0, F_ALU, 1, "add_alu");
        step(cw(0, 0, 1, 0, 0), 9'd0, 1'b0);
        push_exp(0, F_R3, 1, "add_r3");
        push_exp(0, F_WC, 1, "add_wcount");
        step(cw(0, 0, 1, 2, 1), 9'd0, 1'b0);
        push_exp(0, F_MAY, 0, "add_mayor");
        step(9'd0, 9'd0, 1'b0);

        // Fibonacci loop: R3=R1+R2, R1<=R2, R2<=R3.
        m2   = 1;
        prev = 1;
        for (int k = 0; k < 7; k++) begin
            f = fib[k];
            push_exp(0, F_MAY, (prev > 20) ? 1 : 0, $sformatf("fib%0d_mayor_x", k));
            step(cw(0, 0, 1, 0, 0), 9'd0, 1'b0);
            push_exp(0, F_R3, f, $sformatf("fib%0d_r3", k));
            push_exp(0, F_MAY, (prev > 20) ? 1 : 0, $sformatf("fib%0d_mayor_y", k));
            step(cw(3, 0, 1, 2, 1), 9'd0, 1'b0);
            push_exp(0, F_R1, m2, $sformatf("fib%0d_r1", k));
            push_exp(0, F_MAY, (f > 20) ? 1 : 0, $sformatf("fib%0d_mayor_z", k));
            step(cw(3, 0, 2, 0, 1), 9'd0, 1'b0);
            push_exp(0, F_R2, f, $sformatf("fib%0d_r2", k));
            push_exp(0, F_MAY, (f > 20) ? 1 : 0, $sformatf("fib%0d_mayor_w", k));
            step(cw(0, 0, 0, 1, 1), 9'd0, 1'b0);
            m2   = f;
            prev = f;
        end
        push_exp(0, F_WC, 22, "fib_wcount");
        push_exp(0, F_OVF, 0, "fib_ovf");
        step(9'd0, 9'd0, 1'b0);

        // Add overflow on the 200/100 instance; sticky across idle cycles.
        push_exp(1, F_ALU, 44, "ovf_alu");
        step(9'd0, cw(0, 0, 1, 0, 0), 1'b0);
        push_exp(1, F_R3, 44, "ovf_r3");
        push_exp(1, F_OVF, 1, "ovf_flag");
        push_exp(1, F_WC, 1, "ovf_wcount");
        step(9'd0, cw(0, 0, 1, 2, 1), 1'b0);
        for (int k = 0; k < 5; k++) begin
            push_exp(1, F_OVF, 1, $sformatf("ovf_sticky%0d", k));
            step(9'd0, 9'd0, 1'b0);
        end

        // Subtract wrap from defaults.
        push_reset(0, 0, 1, "rst2_a");
        step(9'd0, 9'd0, 1'b1);
        push_exp(0, F_ALU, 255, "sub_alu");
        step(cw(1, 0, 1, 0, 0), 9'd0, 1'b0);
        push_exp(0, F_R3, 255, "sub_r3");
        push_exp(0, F_OVF, 1, "sub_ovf");
        push_exp(0, F_WC, 1, "sub_wcount");
        step(cw(1, 0, 1, 2, 1), 9'd0, 1'b0);
        push_exp(0, F_MAY, 1, "sub_mayor");
        step(9'd0, 9'd0, 1'b0);

        // Invalid write target, loading 255 into the result register meanwhile.
        push_exp(0, F_R1, 0, "inv_r1");
        push_exp(0, F_R2, 1, "inv_r2");
        push_exp(0, F_R3, 255, "inv_r3");
        push_exp(0, F_WC, 1, "inv_wcount");
        push_exp(0, F_ERR, 1, "inv_err");
        step(cw(3, 0, 2, 3, 1), 9'd0, 1'b0);

        // Reset coinciding with a valid write to R1: write is lost.
        push_reset(0, 0, 1, "midrst");
        step(cw(2, 0, 0, 0, 1), 9'd0, 1'b1);
        push_reset(0, 0, 1, "postrst");
        step(9'd0, 9'd0, 1'b0);

        // Write counter wraps 255 -> 0 silently.
        for (int k = 0; k < 256; k++) begin
            push_exp(0, F_WC, (k + 1) % 256, $sformatf("wrap_wc%0d", k));
            step(cw(2, 0, 0, 0, 1), 9'd0, 1'b0);
        end
        push_exp(0, F_OVF, 0, "wrap_ovf");
        push_exp(0, F_ERR, 0, "wrap_err");
        push_exp(0, F_R1, 0, "wrap_r1");
        step(9'd0, 9'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
